// File: rtl/pipe_pkg.sv
// =============================================================================
// Module      : pipe_pkg
// Description : Shared widths, exception cause codes, ID/EX control bit-field
//               offsets and slot-occupancy states for pipe_stage_reg.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package pipe_pkg;

  localparam int DEF_DATA_W  = 128;
  localparam int DEF_CTRL_W  = 24;
  localparam int DEF_CAUSE_W = 4;

  localparam logic [3:0] EXC_NONE     = 4'd0;
  localparam logic [3:0] EXC_ILLEGAL  = 4'd2;
  localparam logic [3:0] EXC_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_ECALL    = 4'd11;

  // ID/EX control payload layout (LSB offset and field width)
  localparam int CTRL_ALUOP_LSB    = 0;
  localparam int CTRL_ALUOP_W      = 5;
  localparam int CTRL_ALUSRC_LSB   = 5;
  localparam int CTRL_MEMREAD_LSB  = 6;
  localparam int CTRL_MEMWRITE_LSB = 7;
  localparam int CTRL_REGWRITE_LSB = 8;
  localparam int CTRL_WDSEL_LSB    = 9;
  localparam int CTRL_WDSEL_W      = 2;
  localparam int CTRL_NPCOP_LSB    = 11;
  localparam int CTRL_NPCOP_W      = 3;
  localparam int CTRL_DMTYPE_LSB   = 14;
  localparam int CTRL_DMTYPE_W     = 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } slot_state_t;

endpackage

`default_nettype wire

// File: rtl/pipe_slot.sv
// =============================================================================
// Module      : pipe_slot
// Description : One pipeline entry: valid bit plus data/ctrl/exc/cause storage.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CTRL_W  = DEF_CTRL_W,
  parameter int CAUSE_W = DEF_CAUSE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_clr,
  input  logic               i_kill,
  input  logic [DATA_W-1:0]  i_data,
  input  logic [CTRL_W-1:0]  i_ctrl,
  input  logic               i_exc,
  input  logic [CAUSE_W-1:0] i_cause,
  output logic               o_valid,
  output logic [DATA_W-1:0]  o_data,
  output logic [CTRL_W-1:0]  o_ctrl,
  output logic               o_exc,
  output logic [CAUSE_W-1:0] o_cause
);

  logic               r_valid;
  logic [DATA_W-1:0]  r_data;
  logic [CTRL_W-1:0]  r_ctrl;
  logic               r_exc;
  logic [CAUSE_W-1:0] r_cause;

  // Data is left untouched on kill/clear so the last value stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= '0;
      r_exc   <= 1'b0;
      r_cause <= '0;
    end else if (i_kill || (i_clr && !i_load)) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_exc   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_ctrl  <= i_ctrl;
      r_exc   <= i_exc;
      r_cause <= i_cause;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ctrl  = r_ctrl;
  assign o_exc   = r_exc;
  assign o_cause = r_cause;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// =============================================================================
// Module      : pipe_stage_reg
// Description : Inter-stage pipeline register with valid/ready handshake,
//               2-entry skid buffer, flush and precise-exception tracking.
//               Optional macro PIPE_STAGE_PERF_EN adds stall/flush counters.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CTRL_W  = DEF_CTRL_W,
  parameter int CAUSE_W = DEF_CAUSE_W,
  parameter int SKID    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic               in_exc,
  input  logic [CAUSE_W-1:0] in_cause,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic               out_exc,
  output logic [CAUSE_W-1:0] out_cause,
  input  logic               flush,
  output logic               exc_pending
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);

  slot_state_t        r_state;
  slot_state_t        w_state_nxt;

  logic               w_m_v, w_m_exc;
  logic [DATA_W-1:0]  w_m_data;
  logic [CTRL_W-1:0]  w_m_ctrl;
  logic [CAUSE_W-1:0] w_m_cause;

  logic               w_s_v, w_s_exc;
  logic [DATA_W-1:0]  w_s_data;
  logic [CTRL_W-1:0]  w_s_ctrl;
  logic [CAUSE_W-1:0] w_s_cause;

  logic               w_acc, w_emit, w_exc_pending;
  logic               w_main_load, w_main_from_skid, w_main_clr;
  logic               w_skid_load, w_skid_clr;

  assign w_exc_pending = (w_m_v && w_m_exc) || (w_s_v && w_s_exc);

  // Skid variant: ready depends only on held state, never on out_ready.
  assign in_ready = (SKID != 0) ? (!w_s_v && !w_exc_pending)
                                : ((!w_m_v || out_ready) && !w_exc_pending);

  assign w_acc  = in_valid && in_ready;
  assign w_emit = w_m_v && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_main_clr       = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clr       = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_acc) begin
          w_main_load = 1'b1;
          w_state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_acc && w_emit) begin
          w_main_load = 1'b1;
        end else if (w_acc && (SKID != 0)) begin
          w_skid_load = 1'b1;
          w_state_nxt = ST_FULL;
        end else if (w_emit) begin
          w_main_clr  = 1'b1;
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_emit) begin
          w_main_load      = 1'b1;
          w_main_from_skid = 1'b1;
          w_skid_clr       = 1'b1;
          w_state_nxt      = ST_ONE;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    if (flush) w_state_nxt = ST_EMPTY;
  end

  pipe_slot #(
    .DATA_W  (DATA_W),
    .CTRL_W  (CTRL_W),
    .CAUSE_W (CAUSE_W)
  ) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_main_load),
    .i_clr   (w_main_clr),
    .i_kill  (flush),
    .i_data  (w_main_from_skid ? w_s_data  : in_data),
    .i_ctrl  (w_main_from_skid ? w_s_ctrl  : in_ctrl),
    .i_exc   (w_main_from_skid ? w_s_exc   : in_exc),
    .i_cause (w_main_from_skid ? w_s_cause : in_cause),
    .o_valid (w_m_v),
    .o_data  (w_m_data),
    .o_ctrl  (w_m_ctrl),
    .o_exc   (w_m_exc),
    .o_cause (w_m_cause)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(
        .DATA_W  (DATA_W),
        .CTRL_W  (CTRL_W),
        .CAUSE_W (CAUSE_W)
      ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skid_load),
        .i_clr   (w_skid_clr),
        .i_kill  (flush),
        .i_data  (in_data),
        .i_ctrl  (in_ctrl),
        .i_exc   (in_exc),
        .i_cause (in_cause),
        .o_valid (w_s_v),
        .o_data  (w_s_data),
        .o_ctrl  (w_s_ctrl),
        .o_exc   (w_s_exc),
        .o_cause (w_s_cause)
      );
    end else begin : g_noskid
      assign w_s_v     = 1'b0;
      assign w_s_data  = '0;
      assign w_s_ctrl  = '0;
      assign w_s_exc   = 1'b0;
      assign w_s_cause = '0;
    end
  endgenerate

  assign out_valid   = w_m_v;
  assign out_data    = w_m_data;
  assign out_ctrl    = w_m_v ? w_m_ctrl : '0;
  assign out_exc     = w_m_v && w_m_exc;
  assign out_cause   = out_exc ? w_m_cause : '0;
  assign exc_pending = w_exc_pending;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_m_v && !out_ready)     r_perf_stall <= r_perf_stall + 32'd1;
      if (flush && (w_m_v || w_s_v)) r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// =============================================================================
// Module      : tb_pipe_stage_reg
// Description : Scoreboard bench for pipe_stage_reg (default SKID=1 build).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = 128;
  localparam int CW = 24;
  localparam int XW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          in_exc = 1'b0;
  logic [XW-1:0] in_cause = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          out_exc;
  logic [XW-1:0] out_cause;
  logic          flush = 1'b0;
  logic          exc_pending;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   perf_stall_cnt;
  logic [31:0]   perf_flush_cnt;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
    logic          exc;
    logic [XW-1:0] cause;
  } entry_t;

  entry_t q[$];
  entry_t e;
  logic   has_exc;
  logic   exp_rdy;
  int     n_tests = 0;
  int     n_fail  = 0;
  int     n_emit  = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_ctrl     (in_ctrl),
    .in_exc      (in_exc),
    .in_cause    (in_cause),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ctrl    (out_ctrl),
    .out_exc     (out_exc),
    .out_cause   (out_cause),
    .flush       (flush),
    .exc_pending (exc_pending)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  // Scoreboard: sampled just before each rising edge, when inputs are settled.
  always @(negedge clk) begin
    #4;
    if (!rst_n) begin
      q.delete();
    end else begin
      has_exc = 1'b0;
      foreach (q[i]) if (q[i].exc) has_exc = 1'b1;
      exp_rdy = (q.size() < 2) && !has_exc;
      n_tests++;
      if (out_valid !== (q.size() != 0)) begin
        n_fail++;
        $display("FAIL sb_valid: out_valid=%b exp=%b", out_valid, (q.size() != 0));
      end
      n_tests++;
      if (in_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL sb_ready: in_ready=%b exp=%b", in_ready, exp_rdy);
      end
      n_tests++;
      if (exc_pending !== has_exc) begin
        n_fail++;
        $display("FAIL sb_exc_pending: exc_pending=%b exp=%b", exc_pending, has_exc);
      end
      if (out_valid !== 1'b1) begin
        n_tests++;
        if (out_ctrl !== '0 || out_exc !== 1'b0 || out_cause !== '0) begin
          n_fail++;
          $display("FAIL sb_bubble: ctrl=%h exc=%b cause=%h exp 0/0/0", out_ctrl, out_exc, out_cause);
        end
      end
      if (flush) begin
        q.delete();
      end else begin
        if (out_valid && out_ready && q.size() != 0) begin
          e = q.pop_front();
          n_emit++;
          n_tests++;
          if (out_data !== e.data || out_ctrl !== e.ctrl || out_exc !== e.exc || out_cause !== e.cause) begin
            n_fail++;
            $display("FAIL sb_emit: got d=%h c=%h x=%b ca=%h exp d=%h c=%h x=%b ca=%h",
                     out_data, out_ctrl, out_exc, out_cause, e.data, e.ctrl, e.exc, e.cause);
          end
        end
        if (in_valid && in_ready) begin
          e.data  = in_data;
          e.ctrl  = in_ctrl;
          e.exc   = in_exc;
          e.cause = in_exc ? in_cause : '0;
          q.push_back(e);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic x, input logic [XW-1:0] ca, input logic ordy, input logic fl);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    in_exc    = x;
    in_cause  = ca;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0 || out_exc !== 1'b0 ||
        out_cause !== '0 || exc_pending !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: v=%b c=%h d=%h x=%b ca=%h ep=%b rdy=%b exp 0,0,0,0,0,0,1",
               out_valid, out_ctrl, out_data, out_exc, out_cause, exc_pending, in_ready);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, DW'(i), 24'hA5, 1'b0, '0, 1'b1, 1'b0);
      #1;
      if (i > 0) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== DW'(i - 1) || out_ctrl !== 24'hA5) begin
          n_fail++;
          $display("FAIL stream_%0d: v=%b d=%h c=%h exp 1/%0d/a5", i, out_valid, out_data, out_ctrl, i - 1);
        end
      end
    end
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== DW'(7) || out_ctrl !== 24'hA5) begin
      n_fail++;
      $display("FAIL stream_last: v=%b d=%h c=%h exp 1/7/a5", out_valid, out_data, out_ctrl);
    end
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_full();
    drive(1'b1, DW'(16'h10), 24'h3C, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, DW'(16'h11), 24'h3D, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    #1;
    n_tests++;
    if (in_ready !== 1'b0 || out_data !== DW'(16'h10)) begin
      n_fail++;
      $display("FAIL full_hold: rdy=%b d=%h exp 0/10", in_ready, out_data);
    end
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_data !== DW'(16'h11) || out_ctrl !== 24'h3D) begin
      n_fail++;
      $display("FAIL full_drain: rdy=%b d=%h c=%h exp 1/11/3d", in_ready, out_data, out_ctrl);
    end
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_ctrl !== '0) begin
      n_fail++;
      $display("FAIL full_empty: v=%b c=%h exp 0/0", out_valid, out_ctrl);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, DW'(16'h20), 24'h11, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, DW'(16'h21), 24'h12, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, DW'(16'h22), 24'h13, 1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1 || exc_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_full: v=%b c=%h rdy=%b ep=%b exp 0/0/1/0", out_valid, out_ctrl, in_ready, exc_pending);
    end
    drive(1'b1, DW'(16'h23), 24'h14, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, DW'(16'h24), 24'h15, 1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_one: v=%b rdy=%b exp 0/1", out_valid, in_ready);
    end
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_discard: v=%b exp 0", out_valid);
    end
  endtask

  task automatic test_exception();
    drive(1'b1, DW'(16'h30), 24'h21, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, DW'(16'h31), 24'h22, 1'b1, EXC_ILLEGAL, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    #1;
    n_tests++;
    if (in_ready !== 1'b0 || exc_pending !== 1'b1 || out_data !== DW'(16'h30) || out_exc !== 1'b0) begin
      n_fail++;
      $display("FAIL exc_hold: rdy=%b ep=%b d=%h x=%b exp 0/1/30/0", in_ready, exc_pending, out_data, out_exc);
    end
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    #1;
    n_tests++;
    if (out_data !== DW'(16'h31) || out_exc !== 1'b1 || out_cause !== 4'd2 || exc_pending !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL exc_head: d=%h x=%b ca=%h ep=%b rdy=%b exp 31/1/2/1/0", out_data, out_exc, out_cause, exc_pending, in_ready);
    end
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || exc_pending !== 1'b0 || in_ready !== 1'b1 || out_exc !== 1'b0 || out_cause !== '0) begin
      n_fail++;
      $display("FAIL exc_clear: v=%b ep=%b rdy=%b x=%b ca=%h exp 0/0/1/0/0", out_valid, exc_pending, in_ready, out_exc, out_cause);
    end
    // Excepting entry alone blocks a waiting younger entry until it leaves
    drive(1'b1, DW'(16'h40), 24'h31, 1'b1, EXC_ECALL, 1'b0, 1'b0);
    drive(1'b1, DW'(16'h41), 24'h32, 1'b0, '0, 1'b0, 1'b0);
    #1;
    n_tests++;
    if (in_ready !== 1'b0 || out_exc !== 1'b1 || out_cause !== 4'd11) begin
      n_fail++;
      $display("FAIL exc_block: rdy=%b x=%b ca=%h exp 0/1/b", in_ready, out_exc, out_cause);
    end
    drive(1'b1, DW'(16'h41), 24'h32, 1'b0, '0, 1'b1, 1'b0);
    drive(1'b1, DW'(16'h41), 24'h32, 1'b0, '0, 1'b1, 1'b0);
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL exc_release: rdy=%b v=%b exp 1/0", in_ready, out_valid);
    end
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    #1;
    n_tests++;
    if (out_data !== DW'(16'h41) || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL exc_younger: d=%h v=%b exp 41/1", out_data, out_valid);
    end
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int emit0;
    emit0 = n_emit;
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom}, CW'($urandom),
            ($urandom_range(0, 15) == 0), XW'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 31) == 0));
    end
    repeat (4) drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    #1;
    n_tests++;
    if (q.size() != 0 || n_emit - emit0 < 50) begin
      n_fail++;
      $display("FAIL b2b_drain: left=%0d emitted=%0d exp 0/>=50", q.size(), n_emit - emit0);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, DW'(16'h50), 24'h41, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, DW'(16'h51), 24'h42, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    #1;
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_full: rdy=%b v=%b exp 0/1", in_ready, out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_ctrl !== '0 || out_exc !== 1'b0 ||
        out_cause !== '0 || exc_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_now: v=%b d=%h c=%h x=%b ca=%h ep=%b exp all 0",
               out_valid, out_data, out_ctrl, out_exc, out_cause, exc_pending);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_release: rdy=%b v=%b exp 1/0", in_ready, out_valid);
    end
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    drive(1'b1, DW'(16'h60), 24'h51, 1'b0, '0, 1'b0, 1'b0);
    repeat (5) drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    #1;
    n_tests++;
    if (perf_stall_cnt !== 32'd5 || perf_flush_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL perf_counts: stall=%0d flush=%0d exp 5/1", perf_stall_cnt, perf_flush_cnt);
    end
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    #1;
    n_tests++;
    if (perf_flush_cnt !== 32'd1 || perf_stall_cnt !== 32'd5) begin
      n_fail++;
      $display("FAIL perf_empty_flush: stall=%0d flush=%0d exp 5/1", perf_stall_cnt, perf_flush_cnt);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_flush();
    test_exception();
    test_back_to_back();
    test_async_reset();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register, the successor to the fixed-field ID/EX latch. Usable for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Carries an opaque data payload plus a control payload. The control payload is forced to zero on a bubble or flush, so downstream never sees side effects (RegWrite, MemWrite, MemRead, ...).
- Adds a valid/ready handshake with a 2-entry skid buffer, so a stall from the next stage needs no combinational ready path.
- Adds a precise-exception tag: the oldest excepting entry is reported and younger entries are squashed.

Parameters:
- DATA_W, 128, width of the data payload (PC, inst, imm, register indices/data); held as-is on a bubble.
- CTRL_W, 24, width of the control payload; zeroed on a bubble or flush.
- CAUSE_W, 4, width of the exception cause code.
- SKID, 1, 1 = 2-entry skid buffer (registered in_ready); 0 = single register, with in_ready = !out_valid || out_ready.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept this cycle
- in_data  in  DATA_W  data payload
- in_ctrl  in  CTRL_W  control payload
- in_exc  in  1  entry carries an exception
- in_cause  in  CAUSE_W  exception cause
- out_valid  out  1  entry presented downstream
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  head data
- out_ctrl  out  CTRL_W  head control; 0 when !out_valid
- out_exc  out  1  head carries an exception
- out_cause  out  CAUSE_W  head cause; 0 when !out_exc
- flush  in  1  synchronous kill of all held entries (branch mispredict or trap)
- exc_pending  out  1  an excepting entry is held in the stage

Behaviour:
- Reset (async, rst_n=0): both slots invalid. out_valid=0, out_ctrl=0, out_data=0, out_exc=0, out_cause=0, exc_pending=0, in_ready=1 on the first cycle after release.
- Accept when in_valid && in_ready. Emit when out_valid && out_ready.
- Latency: 1 cycle, in to out, when unstalled. Throughput: 1 entry per cycle.
- Slots:
  - main = head; skid = overflow.
  - SKID=1: in_ready = !skid_valid (registered).
  - Accept while main is valid and out_ready=0 → entry goes to skid.
  - On emit, skid moves to main in the same edge.
- States (SKID=1): EMPTY, ONE, FULL.
  - EMPTY→ONE on accept.
  - ONE→FULL on accept without emit.
  - ONE→EMPTY on emit without accept.
  - ONE stays ONE on accept together with emit.
  - FULL→ONE on emit. No accept is possible in FULL.
- Order is preserved; no entry is ever dropped except by flush or exception squash.
- Bubble: when !out_valid, out_ctrl=0 and out_exc=0. out_data holds its last value (debug visibility only).
- flush=1 (priority over everything, sampled at the edge):
  - Both slots are invalidated and exc_pending cleared.
  - An input accepted in the same cycle is discarded.
  - out_valid=0 in the next cycle.
  - in_ready=1 in the next cycle.
- Exception:
  - When an entry with in_exc=1 is accepted, the stage sets exc_pending and stops accepting: in_ready=0 until that entry is emitted or flushed.
  - Entries already older than it pass normally.
  - If it is accepted into skid while main is non-excepting, main still emits first.
  - exc_pending clears on the edge at which the excepting entry is emitted.
- Simultaneous accept+emit in ONE: main takes the input and skid stays empty.
- out_ready=1 with out_valid=0 has no effect.
- Reset mid-operation discards everything immediately (asynchronous).

Optional Feature:
- PIPE_STAGE_PERF_EN defined: adds outputs perf_stall_cnt (32b, cycles with out_valid && !out_ready) and perf_flush_cnt (32b, flush pulses that killed ≥1 valid entry).
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: no counters and no ports; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - cause code constants: EXC_NONE=0, EXC_ILLEGAL=2, EXC_ECALL=11, EXC_MISALIGN=4
  - the default widths
  - the ID/EX ctrl bit-field offsets (ALUOp, ALUSrc, MemRead, MemWrite, RegWrite, WDSel, NPCOp, DMType)
- Sub-module pipe_slot: one valid bit plus data/ctrl/exc/cause storage with load and kill inputs, instantiated twice (once when SKID=0).

Test Plan:
- Stream 8 entries (in_data=0..7, in_ctrl=0xA5) with out_ready=1 → out_data 0..7 on consecutive cycles, exactly 1-cycle latency, out_ctrl=0xA5 each cycle.
- Accept entries 0x10 and 0x11 while out_ready=0 → state FULL and in_ready=0. Release out_ready → 0x10 then 0x11 emitted, in_ready=1 the cycle after 0x10 leaves.
- FULL, then flush=1 together with in_valid=1 (data 0x22) → next cycle out_valid=0 and out_ctrl=0. 0x22 never appears; in_ready=1.
- Accept 0x30 (exc=0), then 0x31 (exc=1, cause=2) with out_ready=0 → in_ready=0 and exc_pending=1. Release out_ready → 0x30, then 0x31 with out_exc=1, out_cause=2. exc_pending falls after 0x31 leaves.
- Assert rst_n=0 mid-stream while FULL → outputs zero immediately without a clock edge. After release, in_ready=1.
- With PIPE_STAGE_PERF_EN: hold out_ready=0 for 5 cycles while valid, then flush once → perf_stall_cnt=5 and perf_flush_cnt=1.
